// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle for the execute-stage ALU.
//   master : requester side (drives valid_i, funct_i, ALUOp_i, a_i, b_i;
//            observes ready_o, valid_o, result_o, illegal_o)
//   slave  : the ALU itself (mirror directions)
// Signal names keep their _i/_o suffixes as seen from the ALU.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             valid_i;
  logic             ready_o;
  logic [9:0]       funct_i;   // {funct7, funct3}
  logic [1:0]       ALUOp_i;   // 00 R-type, 10 I-type, 01 branch, 11 reserved
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic             illegal_o;

  modport master (output valid_i, funct_i, ALUOp_i, a_i, b_i,
                  input  ready_o, valid_o, result_o, illegal_o);
  modport slave  (input  valid_i, funct_i, ALUOp_i, a_i, b_i,
                  output ready_o, valid_o, result_o, illegal_o);
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with internal funct/ALUOp decode.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : alu_exec_unit_if.slave (valid/ready request, registered
//            one-cycle valid_o response with result_o/illegal_o)
// Single-cycle ops (and illegal decodes) complete one cycle after accept,
// back-to-back. MUL uses an iterative shift-add engine taking WIDTH
// iterations (latency WIDTH+1) during which ready_o is low.
// Build option: define ALU_FAST_MUL_EN to compute MUL combinationally as a
// single-cycle op; the MUL state is then never entered.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_exec_unit_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, MUL} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILL
  } op_t;

  state_t           state_q, state_d;
  op_t              op;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             illegal_q, valid_q;
  logic             accept, is_mul, mul_done;

  wire [6:0]     f7    = bus.funct_i[9:3];
  wire [2:0]     f3    = bus.funct_i[2:0];
  wire [SHW-1:0] shamt = bus.b_i[SHW-1:0];

  // ---- decode ----
  always_comb begin
    op = OP_ILL;
    case (bus.ALUOp_i)
      2'b00: begin
        // R-type: every funct3 needs funct7 = 0 except the ADD/SUB/MUL and
        // SRL/SRA pairs which select on funct7.
        case (f3)
          3'b000: if (f7 == 7'h00) op = OP_ADD;
                  else if (f7 == 7'h20) op = OP_SUB;
                  else if (f7 == 7'h01) op = OP_MUL;
          3'b001: if (f7 == 7'h00) op = OP_SLL;
          3'b010: if (f7 == 7'h00) op = OP_SLT;
          3'b011: if (f7 == 7'h00) op = OP_SLTU;
          3'b100: if (f7 == 7'h00) op = OP_XOR;
          3'b101: if (f7 == 7'h00) op = OP_SRL;
                  else if (f7 == 7'h20) op = OP_SRA;
          3'b110: if (f7 == 7'h00) op = OP_OR;
          default: if (f7 == 7'h00) op = OP_AND;
        endcase
      end
      2'b10: begin
        // I-type: funct7 only matters for the shift encodings.
        case (f3)
          3'b000: op = OP_ADD;
          3'b001: if (f7 == 7'h00) op = OP_SLL;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b101: if (f7 == 7'h00) op = OP_SRL;
                  else if (f7 == 7'h20) op = OP_SRA;
          3'b110: op = OP_OR;
          default: op = OP_AND;
        endcase
      end
      2'b01:   op = OP_SUB;
      default: op = OP_ILL;
    endcase
  end

  // ---- single-cycle datapath ----
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.a_i + bus.b_i;
      OP_SUB:  alu_res = bus.a_i - bus.b_i;
`ifdef ALU_FAST_MUL_EN
      OP_MUL:  alu_res = bus.a_i * bus.b_i;
`endif
      OP_SLL:  alu_res = bus.a_i << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a_i) < $signed(bus.b_i)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a_i < bus.b_i};
      OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
      OP_SRL:  alu_res = bus.a_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.a_i) >>> shamt);
      OP_OR:   alu_res = bus.a_i | bus.b_i;
      OP_AND:  alu_res = bus.a_i & bus.b_i;
      default: alu_res = '0;
    endcase
  end

  assign accept   = bus.valid_i && (state_q == IDLE);
`ifdef ALU_FAST_MUL_EN
  assign is_mul   = 1'b0;
`else
  assign is_mul   = (op == OP_MUL);
`endif
  assign acc_nxt  = mplier[0] ? acc + mcand : acc;
  // Last iteration is the edge that takes the counter from 1 to 0.
  assign mul_done = (state_q == MUL) && (cnt == CW'(1));

  // ---- FSM ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (accept && is_mul) state_d = MUL;
    end else begin
      if (mul_done) state_d = IDLE;
    end
  end

  // ---- registers ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          if (is_mul) begin
            mcand  <= bus.a_i;
            mplier <= bus.b_i;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
          end else begin
            result_q  <= alu_res;
            illegal_q <= (op == OP_ILL);
            valid_q   <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (mul_done) begin
          result_q  <= acc_nxt;
          illegal_q <= 1'b0;
          valid_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.ready_o   = (state_q == IDLE);
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.illegal_o = illegal_q;
endmodule
